// File: rtl/controller_reader.sv
// Polls two SNES-style serial gamepads over a shared latch/clock pair and publishes
// active-high 10-bit button vectors once per poll. Optional: CONTROLLER_DEBOUNCE_EN.
module controller_reader #(
    parameter int CLK_HALF    = 648,
    parameter int POLL_PERIOD = 1800500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pad_data1,
    input  logic       pad_data2,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [9:0] controller1,
    output logic [9:0] controller2,
    output logic       update
);

    localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int CW = $clog2(2 * CLK_HALF);

    localparam logic [TW-1:0] T_LAST    = TW'(POLL_PERIOD - 1);
    localparam logic [CW-1:0] C_LAST    = CW'(2 * CLK_HALF - 1);
    localparam logic [CW-1:0] C_HALF    = CW'(CLK_HALF);
    localparam logic [CW-1:0] C_SAMPLE  = CW'(CLK_HALF - 1);
    localparam logic [3:0]    BIT_LAST  = 4'd15;
    localparam logic [3:0]    BIT_KEEP  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [TW-1:0] r_timer;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [3:0]    r_bit;
    logic [3:0]    w_bit_next;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [9:0]    r_raw1;
    logic [9:0]    r_raw2;
    logic [9:0]    r_ctrl1;
    logic [9:0]    r_ctrl2;
    logic          r_update;
    logic          w_start;
    logic          w_latch;
    logic          w_pclk;
    logic          w_sample;
    logic          w_done;
`ifdef CONTROLLER_DEBOUNCE_EN
    logic [9:0]    r_prev1;
    logic [9:0]    r_prev2;
`endif

    // Pad data lines are asynchronous to the system clock.
    always_ff @(posedge clock) begin
        r_sync1 <= {r_sync1[0], pad_data1};
        r_sync2 <= {r_sync2[0], pad_data2};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (r_timer == T_LAST) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_start      = (r_state == S_IDLE) && (r_timer == '0);
        w_latch      = 1'b0;
        w_pclk       = 1'b1;
        w_sample     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                w_bit_next = '0;
                if (w_start) begin
                    w_state_next = S_LATCH;
                end
            end
            S_LATCH: begin
                w_latch = 1'b1;
                if (r_cnt == C_LAST) begin
                    w_state_next = S_SHIFT;
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                // Low phase first, then high phase; data is valid by the end of the low phase.
                w_pclk   = (r_cnt >= C_HALF);
                w_sample = (r_cnt == C_SAMPLE);
                if (r_cnt == C_LAST) begin
                    w_cnt_next = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Indices 10..15 (L, R, padding) are shifted out but never stored.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_raw1 <= '0;
            r_raw2 <= '0;
        end else if (w_sample && (r_bit < BIT_KEEP)) begin
            r_raw1[r_bit] <= ~r_sync1[1];
            r_raw2[r_bit] <= ~r_sync2[1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ctrl1  <= '0;
            r_ctrl2  <= '0;
            r_update <= 1'b0;
`ifdef CONTROLLER_DEBOUNCE_EN
            r_prev1  <= '0;
            r_prev2  <= '0;
`endif
        end else begin
            r_update <= w_done;
            if (w_done) begin
`ifdef CONTROLLER_DEBOUNCE_EN
                // Accept a vector only once two consecutive polls agree.
                if (r_raw1 == r_prev1) begin
                    r_ctrl1 <= r_raw1;
                end
                if (r_raw2 == r_prev2) begin
                    r_ctrl2 <= r_raw2;
                end
                r_prev1 <= r_raw1;
                r_prev2 <= r_raw2;
`else
                r_ctrl1 <= r_raw1;
                r_ctrl2 <= r_raw2;
`endif
            end
        end
    end

    assign pad_latch   = w_latch;
    assign pad_clk     = w_pclk;
    assign controller1 = r_ctrl1;
    assign controller2 = r_ctrl2;
    assign update      = r_update;

endmodule

// File: tb/tb_controller_reader.sv
// Scoreboard bench for controller_reader with a behavioural SNES pad model per port.
module tb_controller_reader;

    localparam int HALF = 4;
    localparam int PER  = 200;

    localparam logic [9:0] BTN_B     = 10'h001;
    localparam logic [9:0] BTN_START = 10'h008;
    localparam logic [9:0] BTN_UP    = 10'h010;
    localparam logic [9:0] BTN_A     = 10'h100;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       pad_data1;
    logic       pad_data2;
    logic       pad_latch;
    logic       pad_clk;
    logic [9:0] controller1;
    logic [9:0] controller2;
    logic       update;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] sb_q[$];
    logic [9:0]  m_prev1 = '0;
    logic [9:0]  m_prev2 = '0;
    logic [9:0]  m_out1  = '0;
    logic [9:0]  m_out2  = '0;

    logic [15:0] pat1 = '1;
    logic [15:0] pat2 = '1;
    logic [15:0] sh1  = '1;
    logic [15:0] sh2  = '1;
    logic        pclk_q = 1'b1;

    controller_reader #(
        .CLK_HALF   (HALF),
        .POLL_PERIOD(PER)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pad_data1  (pad_data1),
        .pad_data2  (pad_data2),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .controller1(controller1),
        .controller2(controller2),
        .update     (update)
    );

    always #5 clock = ~clock;

    // Pad: parallel load while latched, shift on each rising pad_clk; B is presented first.
    always @(posedge clock) begin
        pclk_q <= pad_clk;
        if (pad_latch) begin
            sh1 <= pat1;
            sh2 <= pat2;
        end else if (pad_clk && !pclk_q) begin
            sh1 <= {1'b1, sh1[15:1]};
            sh2 <= {1'b1, sh2[15:1]};
        end
    end
    assign pad_data1 = sh1[0];
    assign pad_data2 = sh2[0];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] ser(input logic [9:0] btn, input logic [1:0] lr);
        return ~{4'b0000, lr, btn};
    endfunction

    task automatic push_exp(input logic [9:0] raw1, input logic [9:0] raw2);
`ifdef CONTROLLER_DEBOUNCE_EN
        if (raw1 == m_prev1) m_out1 = raw1;
        if (raw2 == m_prev2) m_out2 = raw2;
        m_prev1 = raw1;
        m_prev2 = raw2;
`else
        m_out1 = raw1;
        m_out2 = raw2;
`endif
        sb_q.push_back({m_out1, m_out2});
    endtask

    task automatic wait_update(input string tag);
        int k;
        k = 0;
        @(negedge clock);
        while (!update && k < 400) begin
            @(negedge clock);
            k++;
        end
        if (!update) check_val({tag, "_timeout"}, {31'd0, update}, 32'd1);
    endtask

    task automatic run_poll(input string tag, input logic [9:0] b1, input logic [9:0] b2,
                            input logic [1:0] lr2);
        pat1 = ser(b1, 2'b00);
        pat2 = ser(b2, lr2);
        push_exp(b1, b2);
        wait_update(tag);
    endtask

    // Scoreboard, periodicity and output-stability monitor.
    int          mon_cyc = 0;
    int          last_upd = 0;
    bit          have_last = 1'b0;
    logic [9:0]  last_c1 = '0;
    logic [9:0]  last_c2 = '0;
    logic [19:0] exp_v;
    always @(negedge clock) begin
        mon_cyc++;
        if (!reset) begin
            have_last = 1'b0;
        end else begin
            if ((controller1 != last_c1) || (controller2 != last_c2))
                check_val("chg_only_on_update", {31'd0, update}, 32'd1);
            if (update) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_unexpected_update", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp_v = sb_q.pop_front();
                    check_val("ctrl1", {22'd0, controller1}, {22'd0, exp_v[19:10]});
                    check_val("ctrl2", {22'd0, controller2}, {22'd0, exp_v[9:0]});
                end
                if (have_last) check_val("update_period", 32'(mon_cyc - last_upd), 32'(PER));
                last_upd  = mon_cyc;
                have_last = 1'b1;
            end
        end
        last_c1 = controller1;
        last_c2 = controller2;
    end

    initial begin
        int n, latch_first, latch_len, pulses, bad_w, low_run, upd_n, viol;

        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_val("rst_ctrl1", {22'd0, controller1}, 32'd0);
        check_val("rst_ctrl2", {22'd0, controller2}, 32'd0);
        check_val("rst_update", {31'd0, update}, 32'd0);
        check_val("rst_latch", {31'd0, pad_latch}, 32'd0);
        check_val("rst_pclk", {31'd0, pad_clk}, 32'd1);

        // First poll: pads idle, cycle-accurate waveform measurement.
        pat1 = ser(10'h000, 2'b00);
        pat2 = ser(10'h000, 2'b00);
        push_exp(10'h000, 10'h000);
        reset = 1'b1;
        n = 0; latch_first = -1; latch_len = 0; pulses = 0; bad_w = 0; low_run = 0; upd_n = -1;
        while (upd_n < 0 && n < 300) begin
            @(negedge clock);
            n++;
            if (pad_latch) begin
                if (latch_first < 0) latch_first = n;
                latch_len++;
            end
            if (!pad_clk) begin
                low_run++;
            end else if (low_run > 0) begin
                pulses++;
                if (low_run != HALF) bad_w++;
                low_run = 0;
            end
            if (update) upd_n = n;
        end
        check_val("latch_rise_cycle", 32'(latch_first), 32'd1);
        check_val("latch_len", 32'(latch_len), 32'(2 * HALF));
        check_val("clk_low_pulses", 32'(pulses), 32'd16);
        check_val("clk_low_width_bad", 32'(bad_w), 32'd0);
        check_val("update_after_latch", 32'(upd_n - latch_first), 32'(34 * HALF + 1));

        viol = 0;
        repeat (50) begin
            @(negedge clock);
            if (pad_clk !== 1'b1 || pad_latch !== 1'b0) viol++;
        end
        check_val("idle_lines", 32'(viol), 32'd0);

        run_poll("idle2", 10'h000, 10'h000, 2'b00);
        run_poll("sa_b_1", BTN_START | BTN_A, BTN_B, 2'b00);
        run_poll("sa_b_2", BTN_START | BTN_A, BTN_B, 2'b00);
        run_poll("p2_lr", BTN_START | BTN_A, BTN_B, 2'b11);
        run_poll("clr_1", 10'h000, 10'h000, 2'b00);
        run_poll("clr_2", 10'h000, 10'h000, 2'b00);
        run_poll("up_once", BTN_UP, 10'h000, 2'b00);
        run_poll("up_rel_1", 10'h000, 10'h000, 2'b00);
        run_poll("up_rel_2", 10'h000, 10'h000, 2'b00);
        run_poll("up_held_1", BTN_UP, 10'h000, 2'b00);
        run_poll("up_held_2", BTN_UP, 10'h000, 2'b00);

        // Abort a poll in the low phase of bit 5.
        pat1 = ser(BTN_START | BTN_A, 2'b00);
        pat2 = ser(BTN_B, 2'b00);
        n = 0;
        while (!pad_latch && n < 400) begin
            @(negedge clock);
            n++;
        end
        check_val("midrst_latch_seen", {31'd0, pad_latch}, 32'd1);
        repeat (2 * HALF + 5 * 2 * HALF + 2) @(negedge clock);
        check_val("midrst_in_low_phase", {31'd0, pad_clk}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_val("midrst_pclk", {31'd0, pad_clk}, 32'd1);
        check_val("midrst_latch", {31'd0, pad_latch}, 32'd0);
        check_val("midrst_ctrl1", {22'd0, controller1}, 32'd0);
        check_val("midrst_ctrl2", {22'd0, controller2}, 32'd0);
        check_val("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
        m_prev1 = '0; m_prev2 = '0; m_out1 = '0; m_out2 = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        run_poll("post_rst_1", BTN_START | BTN_A, BTN_B, 2'b00);
        run_poll("post_rst_2", BTN_START | BTN_A, BTN_B, 2'b00);

        repeat (2) @(negedge clock);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
